// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and ALU op codes for the control unit and its branch evaluator.
package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;
  typedef enum logic [2:0] {FETCH, DECODE, LOAD, STORE, ALU, HALT} cu_state_t;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
endpackage

// File: rtl/control_unit_branch_eval.sv
// branch_eval: combinational branch-taken decision from instruction class and ALU flags.
module branch_eval
  import k_and_s_pkg::*;
(
  input  decoded_instruction_type i_class,
  input  logic                    i_zero,
  input  logic                    i_neg,
  input  logic                    i_uov,
  input  logic                    i_sov,
  output logic                    o_taken
);
  logic w_unused;
  assign w_unused = i_sov;
  always_comb begin
    case (i_class)
      I_BRANCH: o_taken = 1'b1;
      I_BZERO:  o_taken = i_zero;
      I_BNZERO: o_taken = !i_zero;
      I_BNEG:   o_taken = i_neg;
      I_BNNEG:  o_taken = !i_neg;
      I_BOV:    o_taken = i_uov;
      I_BNOV:   o_taken = !i_uov;
      default:  o_taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle FETCH/DECODE/execute sequencer; CU_INSTR_CNT_EN adds a retired-instruction counter.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
`ifdef CU_INSTR_CNT_EN
  ,
  output logic [15:0]             instr_count
`endif
);
  cu_state_t r_state, w_next;
  logic      w_taken;
  branch_eval u_branch_eval (
    .i_class (decoded_instruction),
    .i_zero  (zero_op),
    .i_neg   (neg_op),
    .i_uov   (unsigned_overflow),
    .i_sov   (signed_overflow),
    .o_taken (w_taken)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  always_comb begin
    w_next           = r_state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = OP_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (r_state)
      FETCH: begin
        ir_enable = 1'b1;
        w_next    = DECODE;
      end
      DECODE: begin
        pc_enable = decoded_instruction != I_HALT;
        branch    = w_taken;
        case (decoded_instruction)
          I_LOAD:                          w_next = LOAD;
          I_STORE:                         w_next = STORE;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: w_next = ALU;
          I_HALT:                          w_next = HALT;
          default:                         w_next = FETCH;
        endcase
      end
      LOAD: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        w_next           = FETCH;
      end
      STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        w_next           = FETCH;
      end
      ALU: begin
        write_reg_enable = 1'b1;
        flags_reg_enable = decoded_instruction != I_MOVE;
        operation        = (decoded_instruction == I_AND) ? OP_AND :
                           (decoded_instruction == I_OR || decoded_instruction == I_MOVE) ? OP_OR :
                           (decoded_instruction == I_SUB) ? OP_SUB : OP_ADD;
        w_next           = FETCH;
      end
      HALT: halt = 1'b1;
      default: w_next = FETCH;
    endcase
    // reset parks in FETCH, but nothing may strobe until rst_n is released
    if (!rst_n)
      {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
       write_reg_enable, flags_reg_enable, ram_write_enable, halt} = '0;
  end
`ifdef CU_INSTR_CNT_EN
  logic [15:0] r_instr_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_instr_count <= '0;
    else if (r_state == DECODE && decoded_instruction != I_HALT) r_instr_count <= r_instr_count + 16'd1;
  assign instr_count = r_instr_count;
`endif
endmodule
